// File: rtl/led_pwm_driver_if.sv
// PWM driver interface: duty/enable request in, LED drive and status out.
interface led_pwm_driver_if #(
  parameter int unsigned CW = 32
);
  logic          en;
  logic [31:0]   duty_in;
  logic          pwm_out;
  logic          period_start;
  logic [CW-1:0] duty_q;
  logic          sat;

  // Driver side: supplies enable and duty, observes the LED and status.
  modport master (
    output en, duty_in,
    input  pwm_out, period_start, duty_q, sat
  );

  // PWM block side.
  modport slave (
    input  en, duty_in,
    output pwm_out, period_start, duty_q, sat
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Fixed-period PWM LED driver fed by the ramp counter.
// Duty is clamped to PERIOD and double-buffered into duty_q so that it only changes
// at a period boundary (or continuously while disabled).
// Optional feature macro: PWM_MIN_ON_EN -- duties in 1..MIN_ON-1 are forced to 0 at load.
module led_pwm_driver #(
  parameter int unsigned PERIOD = 10,
  parameter int unsigned CW     = 32,
  parameter int unsigned MIN_ON = 2
) (
  input  logic              clk,
  input  logic              rst,
  led_pwm_driver_if.slave   bus
);

`ifdef PWM_MIN_ON_EN
  localparam bit MIN_ON_EN = 1'b1;
`else
  localparam bit MIN_ON_EN = 1'b0;
`endif

  localparam logic [31:0]   PERIOD_W = 32'(PERIOD);
  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_ON);

  logic [CW-1:0] cnt;
  logic          clamp;
  logic [CW-1:0] duty_sat;
  logic [CW-1:0] duty_ld;
  logic          wrap;
  logic          load;

  // Clamp is decided on the full 32-bit request before narrowing to CW.
  assign clamp    = bus.duty_in > PERIOD_W;
  assign duty_sat = clamp ? PERIOD_C : CW'(bus.duty_in);
  // With the min-on feature, sub-visible duties collapse to fully off instead of flickering.
  assign duty_ld  = (MIN_ON_EN && (duty_sat != '0) && (duty_sat < MIN_C)) ? '0 : duty_sat;

  assign wrap = (cnt == LAST);
  // While disabled the shadow tracks the request every cycle; while running only at the wrap.
  assign load = !bus.en || wrap;

  // Period counter, shadow duty and registered outputs; outputs use pre-edge cnt/duty_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      bus.duty_q       <= '0;
      bus.pwm_out      <= 1'b0;
      bus.period_start <= 1'b0;
      bus.sat          <= 1'b0;
    end else begin
      bus.pwm_out      <= bus.en && (cnt < bus.duty_q);
      bus.period_start <= bus.en && (cnt == '0);
      bus.sat          <= load && clamp;
      if (load)
        bus.duty_q <= duty_ld;
      cnt <= (!bus.en || wrap) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver (PERIOD=10, CW=32, MIN_ON=2).
// Table vectors cover steady-state duties, shadow timing, boundaries and saturation;
// hand-written sequence covers enable drop/re-raise and mid-period reset.
module tb_led_pwm_driver;

`ifdef PWM_MIN_ON_EN
  localparam bit MINON = 1'b1;
`else
  localparam bit MINON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  led_pwm_driver_if #(.CW(32)) bus ();

  led_pwm_driver #(.PERIOD(10), .CW(32), .MIN_ON(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] d;
    logic        pwm;
    logic        ps;
    logic [31:0] dq;
    logic        sat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input int unsigned d,
                              input logic pwm, input logic ps, input int unsigned dq,
                              input logic sat);
    vec_t v;
    v.rst = r; v.en = e; v.d = d; v.pwm = pwm; v.ps = ps; v.dq = dq; v.sat = sat;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge, check outputs 1ns after the rising edge.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    rst         = v.rst;
    bus.en      = v.en;
    bus.duty_in = v.d;
    @(posedge clk);
    #1;
    chk({tag, ".pwm"}, 32'(bus.pwm_out),      32'(v.pwm));
    chk({tag, ".ps"},  32'(bus.period_start), 32'(v.ps));
    chk({tag, ".dq"},  bus.duty_q,            v.dq);
    chk({tag, ".sat"}, 32'(bus.sat),          32'(v.sat));
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("%s%0d", tag, i), tbl[i]);
    tbl.delete();
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.duty_in = 32'd0;

    // Reset two cycles, then preload duty 3 while disabled.
    add(1, 0, 3, 0, 0, 0, 0);
    add(1, 0, 3, 0, 0, 0, 0);
    add(0, 0, 3, 0, 0, 3, 0);
    // Period 1: duty 3 -> 3 high, 7 low.
    for (int k = 0; k < 10; k++) add(0, 1, 3, k < 3, k == 0, 3, 0);
    // Period 2: request goes 3->7 at cnt==4; this period stays 3-high, dq=7 at the wrap.
    for (int k = 0; k < 10; k++)
      add(0, 1, (k < 4) ? 3 : 7, k < 3, k == 0, (k == 9) ? 7 : 3, 0);
    // Period 3: duty 7; request drops to 0 at cnt==7.
    for (int k = 0; k < 10; k++)
      add(0, 1, (k < 7) ? 7 : 0, k < 7, k == 0, (k == 9) ? 0 : 7, 0);
    // Period 4: duty 0 -> never high; request 10 from cnt==7.
    for (int k = 0; k < 10; k++)
      add(0, 1, (k < 7) ? 0 : 10, 0, k == 0, (k == 9) ? 10 : 0, 0);
    // Period 5: duty 10 -> always high, no sat; request 15 at cnt==8 clamps at the load.
    for (int k = 0; k < 10; k++)
      add(0, 1, (k < 8) ? 10 : 15, 1, k == 0, 10, k == 9);
    // Period 6: duty_in 15 held -> one sat pulse at the load, still continuously high.
    for (int k = 0; k < 10; k++) add(0, 1, 15, 1, k == 0, 10, k == 9);
    run_table("A");

    // Enable drop at cnt==5 with duty 8, re-raise, then reset at cnt==6.
    begin
      vec_t v;
      for (int k = 0; k < 10; k++) begin
        v = '{rst: 0, en: 1, d: 8, pwm: 1, ps: (k == 0), dq: (k == 9) ? 8 : 10, sat: 0};
        step($sformatf("E%0d", k), v);
      end
      for (int k = 0; k < 5; k++) begin
        v = '{rst: 0, en: 1, d: 8, pwm: 1, ps: (k == 0), dq: 8, sat: 0};
        step($sformatf("F%0d", k), v);
      end
      v = '{rst: 0, en: 0, d: 8, pwm: 0, ps: 0, dq: 8, sat: 0};
      step("drop0", v);
      step("drop1", v);
      for (int k = 0; k < 6; k++) begin
        v = '{rst: 0, en: 1, d: 8, pwm: 1, ps: (k == 0), dq: 8, sat: 0};
        step($sformatf("G%0d", k), v);
      end
      v = '{rst: 1, en: 1, d: 8, pwm: 0, ps: 0, dq: 0, sat: 0};
      step("midrst", v);
      v = '{rst: 0, en: 1, d: 8, pwm: 0, ps: 1, dq: 0, sat: 0};
      step("postrst", v);
    end

    // Disabled: clamp pulses every cycle it occurs; exact PERIOD does not clamp.
    add(0, 0, 20, 0, 0, 10, 1);
    add(0, 0, 20, 0, 0, 10, 1);
    add(0, 0, 10, 0, 0, 10, 0);
    // Duty 1: 1-high/9-low, or fully off with the min-on feature.
    add(0, 0, 1, 0, 0, MINON ? 0 : 1, 0);
    for (int k = 0; k < 10; k++) add(0, 1, 1, !MINON && (k == 0), k == 0, MINON ? 0 : 1, 0);
    // Duty 2: 2-high/8-low in both builds.
    add(0, 0, 2, 0, 0, 2, 0);
    for (int k = 0; k < 10; k++) add(0, 1, 2, k < 2, k == 0, 2, 0);
    run_table("B");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
